text_overlay_engine: RTL and testbench
======================================

Name: text_overlay_engine

Overview:
- Parametrised successor to the single-glyph HDMI overlay. It renders a row of N_CHARS font glyphs at a programmable (x, y) over the live pixel stream, between the pattern generator and the HDMI_TX_D pins.
- Character codes are double-buffered, so a new frame is never torn.
- The font ROM is external and synchronous. Sync/DE are pipelined so they stay aligned with pixel data.
- Runs entirely in the 108 MHz pixel clock domain (1280x1024).

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 1024, active lines per frame
- GLYPH_W, 16, glyph width in pixels (power of two)
- GLYPH_H, 32, glyph height in lines
- N_CHARS, 8, characters per string (power of two)
- CODE_W, 8, character code width
- SYNC_ACT_LOW, 1, 1 = in_hs/in_vs asserted low

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- in_hs  in  1  hsync from sync generator
- in_vs  in  1  vsync from sync generator
- in_de  in  1  data enable
- in_rgb  in  24  background pixel {R,G,B}
- wr_en  in  1  write one character code to the shadow buffer
- wr_idx  in  log2(N_CHARS)  character slot
- wr_code  in  CODE_W  character code
- pos_x  in  11  left edge of string, pixels
- pos_y  in  11  top edge of string, lines
- mode  in  2  0=off, 1=transparent, 2=opaque box, 3=inverse
- fg_rgb  in  24  glyph colour
- bg_rgb  in  24  box colour (mode 2)
- rom_addr  out  CODE_W+log2(GLYPH_H)  = code*GLYPH_H + glyph row
- rom_q  in  GLYPH_W  glyph row; valid 1 clk after rom_addr; MSB = leftmost pixel
- out_hs  out  1  in_hs delayed by LAT
- out_vs  out  1  in_vs delayed by LAT
- out_de  out  1  in_de delayed by LAT
- out_rgb  out  24  composited pixel

Behaviour:
- Reset: out_hs/out_vs = inactive level per SYNC_ACT_LOW, out_de=0, out_rgb=0, rom_addr=0, all counters 0, shadow and active codes 0, latched mode=0 (off).
- Latency LAT=3 clk from in_* to out_*, constant for all modes including off. Stages:
  - S1: counters and box test; rom_addr registered.
  - S2: rom_q returns; column index delayed to match.
  - S3: bit select and colour mux; outputs registered.
- x_cnt:
  - 0 while in_de=0.
  - Increments on each in_de=1 cycle.
  - Saturates at H_ACTIVE-1.
- y_cnt:
  - 0 while vsync is asserted.
  - Increments on each falling edge of in_de.
  - Saturates at V_ACTIVE-1.
- Frame latch on the first cycle vsync asserts: shadow codes -> active codes; pos_x, pos_y, mode, fg_rgb, bg_rgb -> working registers. None of these change mid-frame.
- wr_en coinciding with the latch cycle: the copy takes the pre-write shadow value; the new code appears in the following frame.
- Box test (per pixel): hit when all of:
  - in_de=1
  - pos_x <= x_cnt < pos_x + N_CHARS*GLYPH_W
  - pos_y <= y_cnt < pos_y + GLYPH_H
- Index decode on a hit:
  - char = (x_cnt-pos_x)/GLYPH_W
  - col = (x_cnt-pos_x)%GLYPH_W
  - row = y_cnt-pos_y
- Index arithmetic: 12-bit unsigned, no wrap. Any part of the box beyond H_ACTIVE/V_ACTIVE is clipped, never wrapped to line/frame start.
- rom_addr holds its last value outside the box.
- Composite (bit = rom_q[GLYPH_W-1-col]):
  - mode 0: in_rgb.
  - mode 1: bit ? fg_rgb : in_rgb.
  - mode 2: bit ? fg_rgb : bg_rgb.
  - mode 3: bit ? ~in_rgb : in_rgb.
  - Outside the box: in_rgb.
  - When out_de=0: out_rgb=0.
- Reset asserted mid-frame: all state clears next clk; overlay stays off until the next vsync latch.

Test Plan:
- Reset, then hold in_de=1 for 5 cycles with in_rgb=24'h123456 -> out_de rises exactly 3 clk after in_de; out_rgb=24'h123456; out_hs/out_vs track inputs with 3 clk delay.
- Write code 8'h41 to slot 0, mode=1, pos=(300,500), vsync, then a frame with ROM row 0 = 16'h8001 -> line 500 pixels 300 and 315 = fg_rgb; 301..314 = in_rgb; rom_addr = 8'h41*32 = 2080 during the box.
- mode=2, bg_rgb=24'h0000FF, all-zero glyph -> box 128x32 at (300,500) is solid 24'h0000FF; pixel 428 = in_rgb.
- wr_en to slot 3 on the same cycle vsync asserts -> old code rendered in that frame, new code in the next.
- pos=(1270,1010) -> only columns 1270..1279 and lines 1010..1023 altered; column 0 and line 0 of the next frame untouched.
- Assert reset during line 510 with mode=3 -> from the next clk out_rgb=0 and out_de=0; after release the overlay is absent until the next vsync latch.

Source files
------------

// File: rtl/text_overlay_engine.sv
// Renders a row of N_CHARS glyphs from an external synchronous font ROM over a
// live pixel stream, with a fixed three-stage pipeline from in_* to out_*.
module text_overlay_engine #(
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 1024,
  parameter int GLYPH_W      = 16,
  parameter int GLYPH_H      = 32,
  parameter int N_CHARS      = 8,
  parameter int CODE_W       = 8,
  parameter bit SYNC_ACT_LOW = 1'b1,
  localparam int IDX_W  = (N_CHARS > 1) ? $clog2(N_CHARS) : 1,
  localparam int ROW_W  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
  localparam int COL_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  localparam int ADDR_W = CODE_W + ROW_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_hs_i,
  input  logic              in_vs_i,
  input  logic              in_de_i,
  input  logic [23:0]       in_rgb_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [CODE_W-1:0] wr_code_i,
  input  logic [10:0]       pos_x_i,
  input  logic [10:0]       pos_y_i,
  input  logic [1:0]        mode_i,
  input  logic [23:0]       fg_rgb_i,
  input  logic [23:0]       bg_rgb_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [GLYPH_W-1:0] rom_q_i,
  output logic              out_hs_o,
  output logic              out_vs_o,
  output logic              out_de_o,
  output logic [23:0]       out_rgb_o
);

  localparam logic             SYNC_IDLE = SYNC_ACT_LOW;
  localparam logic [10:0]      X_MAX     = 11'(H_ACTIVE - 1);
  localparam logic [10:0]      Y_MAX     = 11'(V_ACTIVE - 1);
  localparam logic [11:0]      BOX_W     = 12'(N_CHARS * GLYPH_W);
  localparam logic [11:0]      BOX_H     = 12'(GLYPH_H);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(GLYPH_W - 1);

  logic              vsAct;
  logic              frameLatch;
  logic              fallDe;
  logic              vsPrev_q;
  logic              dePrev_q;
  logic [10:0]       xCnt_q, xCnt_d;
  logic [10:0]       yCnt_q, yCnt_d;

  logic [CODE_W-1:0] shadow_q [N_CHARS];
  logic [CODE_W-1:0] active_q [N_CHARS];
  logic [10:0]       posX_q, posY_q;
  logic [1:0]        mode_q;
  logic [23:0]       fgRgb_q, bgRgb_q;

  logic [11:0]       xExt, yExt, xLo, yLo, dx, dy;
  logic              boxHit;
  logic [IDX_W-1:0]  charIdx;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] romAddr_d, romAddr_q;

  logic              hs1_q, vs1_q, de1_q, hit1_q;
  logic [23:0]       rgb1_q;
  logic [COL_W-1:0]  col1_q;
  logic              hs2_q, vs2_q, de2_q, hit2_q;
  logic [23:0]       rgb2_q;
  logic [COL_W-1:0]  col2_q;

  logic              glyphBit;
  logic [23:0]       pix_d;
  logic              outHs_q, outVs_q, outDe_q;
  logic [23:0]       outRgb_q;

  assign vsAct      = (in_vs_i != SYNC_IDLE);
  assign frameLatch = vsAct && !vsPrev_q;
  assign fallDe     = dePrev_q && !in_de_i;

  always_comb begin
    xCnt_d = 11'd0;
    if (in_de_i) begin
      xCnt_d = (xCnt_q == X_MAX) ? xCnt_q : xCnt_q + 11'd1;
    end
    yCnt_d = yCnt_q;
    if (vsAct) begin
      yCnt_d = 11'd0;
    end else if (fallDe && (yCnt_q != Y_MAX)) begin
      yCnt_d = yCnt_q + 11'd1;
    end
  end

  // 12-bit compares so a box extending past the raster is clipped, not wrapped.
  always_comb begin
    xExt    = {1'b0, xCnt_q};
    yExt    = {1'b0, yCnt_q};
    xLo     = {1'b0, posX_q};
    yLo     = {1'b0, posY_q};
    dx      = xExt - xLo;
    dy      = yExt - yLo;
    boxHit  = in_de_i && (xExt >= xLo) && (xExt < xLo + BOX_W) &&
              (yExt >= yLo) && (yExt < yLo + BOX_H);
    charIdx = IDX_W'(dx >> COL_W);
    col     = COL_W'(dx);
    row     = ROW_W'(dy);
    romAddr_d = romAddr_q;
    if (boxHit) begin
      romAddr_d = ADDR_W'(active_q[charIdx]) * ADDR_W'(GLYPH_H) + ADDR_W'(row);
    end
  end

  // Working copies only move on the vsync edge so a frame is never torn.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsPrev_q <= 1'b0;
      dePrev_q <= 1'b0;
      xCnt_q   <= 11'd0;
      yCnt_q   <= 11'd0;
      posX_q   <= 11'd0;
      posY_q   <= 11'd0;
      mode_q   <= 2'd0;
      fgRgb_q  <= 24'd0;
      bgRgb_q  <= 24'd0;
      for (int i = 0; i < N_CHARS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      vsPrev_q <= vsAct;
      dePrev_q <= in_de_i;
      xCnt_q   <= xCnt_d;
      yCnt_q   <= yCnt_d;
      if (frameLatch) begin
        active_q <= shadow_q;
        posX_q   <= pos_x_i;
        posY_q   <= pos_y_i;
        mode_q   <= mode_i;
        fgRgb_q  <= fg_rgb_i;
        bgRgb_q  <= bg_rgb_i;
      end
      if (wr_en_i) begin
        shadow_q[wr_idx_i] <= wr_code_i;
      end
    end
  end

  always_comb begin
    glyphBit = rom_q_i[COL_LAST - col2_q];
    pix_d    = rgb2_q;
    if (hit2_q) begin
      case (mode_q)
        2'd1:    if (glyphBit) pix_d = fgRgb_q;
        2'd2:    pix_d = glyphBit ? fgRgb_q : bgRgb_q;
        2'd3:    if (glyphBit) pix_d = ~rgb2_q;
        default: pix_d = rgb2_q;
      endcase
    end
    if (!de2_q) begin
      pix_d = 24'd0;
    end
  end

  // S1 issues the ROM read, S2 waits for rom_q, S3 composites.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      romAddr_q <= '0;
      hs1_q     <= SYNC_IDLE;
      vs1_q     <= SYNC_IDLE;
      de1_q     <= 1'b0;
      hit1_q    <= 1'b0;
      rgb1_q    <= 24'd0;
      col1_q    <= '0;
      hs2_q     <= SYNC_IDLE;
      vs2_q     <= SYNC_IDLE;
      de2_q     <= 1'b0;
      hit2_q    <= 1'b0;
      rgb2_q    <= 24'd0;
      col2_q    <= '0;
      outHs_q   <= SYNC_IDLE;
      outVs_q   <= SYNC_IDLE;
      outDe_q   <= 1'b0;
      outRgb_q  <= 24'd0;
    end else begin
      romAddr_q <= romAddr_d;
      hs1_q     <= in_hs_i;
      vs1_q     <= in_vs_i;
      de1_q     <= in_de_i;
      hit1_q    <= boxHit;
      rgb1_q    <= in_rgb_i;
      col1_q    <= col;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      de2_q     <= de1_q;
      hit2_q    <= hit1_q;
      rgb2_q    <= rgb1_q;
      col2_q    <= col1_q;
      outHs_q   <= hs2_q;
      outVs_q   <= vs2_q;
      outDe_q   <= de2_q;
      outRgb_q  <= pix_d;
    end
  end

  assign rom_addr_o = romAddr_q;
  assign out_hs_o   = outHs_q;
  assign out_vs_o   = outVs_q;
  assign out_de_o   = outDe_q;
  assign out_rgb_o  = outRgb_q;

endmodule

// File: tb/tb_text_overlay_engine.sv
// Randomized-pixel bench for text_overlay_engine: a frame-level reference model
// predicts every output pixel and ROM address from the overlay rules.
module tb_text_overlay_engine;

  localparam int GW = 16;
  localparam int GH = 32;
  localparam int NC = 8;
  localparam int HA = 1280;
  localparam int VA = 1024;
  localparam logic [26:0] RST_OUT = {1'b1, 1'b1, 1'b0, 24'h0};

  logic        clk = 1'b0;
  logic        reset;
  logic        inHs, inVs, inDe;
  logic [23:0] inRgb;
  logic        wrEn;
  logic [2:0]  wrIdx;
  logic [7:0]  wrCode;
  logic [10:0] posX, posY;
  logic [1:0]  mode;
  logic [23:0] fgRgb, bgRgb;
  logic [12:0] romAddr;
  logic [15:0] romQ;
  logic        outHs, outVs, outDe;
  logic [23:0] outRgb;
  logic [15:0] romMem [8192];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mShadow [NC];
  logic [7:0]  mActive [NC];
  int          mPosX, mPosY, mX, mY, mAddr;
  logic [1:0]  mMode;
  logic [23:0] mFg, mBg;
  bit          mDePrev, mVsPrev;
  logic [26:0] expQ [$];

  always #5 clk = ~clk;

  always @(posedge clk) romQ <= romMem[romAddr];

  text_overlay_engine dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_hs_i    (inHs),
    .in_vs_i    (inVs),
    .in_de_i    (inDe),
    .in_rgb_i   (inRgb),
    .wr_en_i    (wrEn),
    .wr_idx_i   (wrIdx),
    .wr_code_i  (wrCode),
    .pos_x_i    (posX),
    .pos_y_i    (posY),
    .mode_i     (mode),
    .fg_rgb_i   (fgRgb),
    .bg_rgb_i   (bgRgb),
    .rom_addr_o (romAddr),
    .rom_q_i    (romQ),
    .out_hs_o   (outHs),
    .out_vs_o   (outVs),
    .out_de_o   (outDe),
    .out_rgb_o  (outRgb)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s #%0d: observed %h, expected %h", tag, vectors, obs, exp);
    end
  endtask

  // Reference model: one call per sampled input pixel.
  task automatic modelStep();
    bit          vsA, hit, glyphBit;
    int          dx;
    logic [23:0] pix;
    vsA = (inVs == 1'b0);
    if (reset) begin
      foreach (mShadow[i]) begin
        mShadow[i] = 8'h00;
        mActive[i] = 8'h00;
      end
      mPosX = 0; mPosY = 0; mMode = 2'd0; mFg = 24'h0; mBg = 24'h0;
      mX = 0; mY = 0; mDePrev = 1'b0; mVsPrev = 1'b0; mAddr = 0;
      expQ.delete();
      repeat (3) expQ.push_back(RST_OUT);
      return;
    end
    hit = inDe && (mX >= mPosX) && (mX < mPosX + NC * GW) &&
          (mY >= mPosY) && (mY < mPosY + GH);
    pix = inRgb;
    if (hit) begin
      dx       = mX - mPosX;
      mAddr    = int'(mActive[dx / GW]) * GH + (mY - mPosY);
      glyphBit = romMem[mAddr][GW - 1 - (dx % GW)];
      case (mMode)
        2'd1: if (glyphBit) pix = mFg;
        2'd2: pix = glyphBit ? mFg : mBg;
        2'd3: if (glyphBit) pix = ~inRgb;
        default: pix = inRgb;
      endcase
    end
    if (!inDe) pix = 24'h0;
    expQ.push_back({inHs, inVs, inDe, pix});
    if (vsA && !mVsPrev) begin
      foreach (mActive[i]) mActive[i] = mShadow[i];
      mPosX = int'(posX); mPosY = int'(posY); mMode = mode; mFg = fgRgb; mBg = bgRgb;
    end
    if (wrEn) mShadow[wrIdx] = wrCode;
    if (!inDe) mX = 0;
    else if (mX < HA - 1) mX++;
    if (vsA) mY = 0;
    else if (mDePrev && !inDe && mY < VA - 1) mY++;
    mDePrev = inDe;
    mVsPrev = vsA;
  endtask

  task automatic applyStimulus(input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
    logic [26:0] expv;
    inDe  = de;
    inHs  = hs ? 1'b0 : 1'b1;
    inVs  = vs ? 1'b0 : 1'b1;
    inRgb = rgb;
    @(posedge clk);
    modelStep();
    #1;
    if (expQ.size() >= 3) begin
      expv = expQ.pop_front();
      checkOutput("pixel", {5'd0, outHs, outVs, outDe, outRgb}, {5'd0, expv});
    end
    checkOutput("rom_addr", 32'(romAddr), 32'(mAddr));
  endtask

  task automatic blank(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic line(input int len);
    for (int i = 0; i < len; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic gotoLine(input int n);
    while (mY < n) line(1);
  endtask

  task automatic vsyncWrite(input bit doWr, input logic [2:0] idx, input logic [7:0] code);
    wrEn = doWr; wrIdx = idx; wrCode = code;
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
    wrEn = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
    blank(2);
  endtask

  task automatic writeCode(input logic [2:0] idx, input logic [7:0] code);
    wrEn = 1'b1; wrIdx = idx; wrCode = code;
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    wrEn = 1'b0;
  endtask

  initial begin
    foreach (romMem[i]) romMem[i] = 16'h0;
    reset = 1'b1; wrEn = 1'b0; wrIdx = 3'd0; wrCode = 8'h0;
    posX = 11'd0; posY = 11'd0; mode = 2'd0; fgRgb = 24'h0; bgRgb = 24'h0;

    $display("[TB] reset and passthrough latency");
    blank(2);
    reset = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 24'h123456);
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    blank(4);
    vsyncWrite(1'b0, 3'd0, 8'h0);

    $display("[TB] transparent glyph at (300,500)");
    romMem[8'h41 * GH] = 16'h8001;
    for (int r = 1; r < GH; r++) romMem[8'h41 * GH + r] = 16'($urandom);
    writeCode(3'd0, 8'h41);
    posX = 11'd300; posY = 11'd500; mode = 2'd1; fgRgb = 24'hFF8000;
    vsyncWrite(1'b0, 3'd0, 8'h0);
    gotoLine(500); line(440); line(440);
    gotoLine(531); line(440); line(440);

    $display("[TB] opaque box with blank glyphs");
    for (int i = 0; i < NC; i++) writeCode(3'(i), 8'h20);
    mode = 2'd2; bgRgb = 24'h0000FF;
    vsyncWrite(1'b0, 3'd0, 8'h0);
    gotoLine(500); line(440);
    gotoLine(531); line(440);

    $display("[TB] write on the latch cycle");
    for (int r = 0; r < GH; r++) romMem[8'h5A * GH + r] = 16'($urandom) | 16'h0101;
    mode = 2'd1; fgRgb = 24'h00FF00;
    vsyncWrite(1'b1, 3'd3, 8'h5A);
    gotoLine(500); line(440);
    gotoLine(510); line(440);
    vsyncWrite(1'b0, 3'd0, 8'h0);
    gotoLine(500); line(440);

    $display("[TB] clipping at the bottom-right corner");
    writeCode(3'd0, 8'h41);
    posX = 11'd1270; posY = 11'd1010; mode = 2'd2;
    fgRgb = 24'($urandom); bgRgb = 24'($urandom);
    vsyncWrite(1'b0, 3'd0, 8'h0);
    gotoLine(1010); line(HA);
    gotoLine(1016); line(HA);
    gotoLine(1023); line(HA);
    vsyncWrite(1'b0, 3'd0, 8'h0);
    line(HA);

    $display("[TB] reset mid-frame with inverse mode");
    posX = 11'd300; posY = 11'd500; mode = 2'd3;
    vsyncWrite(1'b0, 3'd0, 8'h0);
    gotoLine(510);
    repeat (350) applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom));
    reset = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom));
    reset = 1'b0;
    repeat (90) applyStimulus(1'b1, 1'b0, 1'b0, 24'($urandom));
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    blank(1);
    line(440); line(440);
    vsyncWrite(1'b0, 3'd0, 8'h0);
    gotoLine(500); line(440);
    blank(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
